us_shot_sequencer: RTL and testbench
====================================

# us_shot_sequencer

Upstream shot sequencer for the ultrasound transmit path. It accepts a burst configuration (pulse timing, shot period, shot count) and issues `START` pulses to the transmit switch at a fixed pulse-repetition interval. It holds the per-shot timing words stable for the downstream transmit switch and reports busy, done and configuration-error status to the controlling logic.

## Interface
Parameters:
- `REG_WIDTH`, 8: width of `init_delay`, `tx_len`, `damp_len`; matches the transmit switch.
- `PERIOD_WIDTH`, 16: width of `shot_period`.
- `CNT_WIDTH`, 8: width of `num_shots` and `SHOT_IDX`.

Ports:
- `CLK`  in  1: clock.
- `RESET`  in  1: reset, asynchronous, active-high.
- `ARM`  in  1: begin a burst. Sampled only in IDLE.
- `ABORT`  in  1: stop issuing shots. Sampled in every non-IDLE state.
- `init_delay`, `tx_len`, `damp_len`  in  REG_WIDTH each: requested per-shot timing.
- `shot_period`  in  PERIOD_WIDTH: START-to-START spacing, in cycles.
- `num_shots`  in  CNT_WIDTH: shots per burst; 0 means continuous until ABORT.
- `START`  out  1: one-cycle pulse to the transmit switch.
- `init_delay_o`, `tx_len_o`, `damp_len_o`  out  REG_WIDTH each: captured timing, stable for the whole burst.
- `BUSY`  out  1: high from the LOAD state until the sequencer returns to IDLE.
- `DONE`  out  1: one-cycle pulse when a burst completes normally.
- `ERR_CFG`  out  1: one-cycle pulse when a configuration is rejected.
- `SHOT_IDX`  out  CNT_WIDTH: index of the last issued shot, starting at 0.

## Operation
- Reset values: all outputs 0; state IDLE.
- **IDLE**
  - ARM=1: capture every configuration input into shadow registers (they drive the `_o` outputs), then go to LOAD.
  - Configuration changes after capture are ignored until the next ARM.
- **LOAD** (one cycle). Compute `min_period = init_delay + tx_len + damp_len + 4` at REG_WIDTH+2 bits, with no overflow. Zero-extend to compare with `shot_period`.
  - If `shot_period < min_period` or `shot_period == 0`: pulse ERR_CFG, go to IDLE. No START is issued.
  - Otherwise go to FIRE.
- **FIRE** (one cycle).
  - Actions: START=1; load the period counter with `shot_period-1`; increment the shot counter; set SHOT_IDX to the new shot's index.
  - Transition: go to WAIT.
- **WAIT**: decrement the period counter each cycle. When the counter reaches 0:
  - if `num_shots==0`, or fewer than `num_shots` shots have been issued: go to FIRE;
  - otherwise: go to FINISH.
- **FINISH** (one cycle): pulse DONE, go to IDLE.
- **ABORT**
  - In LOAD: go to IDLE. No START, no DONE.
  - In FIRE or WAIT: no further START. Go to DRAIN, which keeps counting down the current period. At 0, go to IDLE without DONE. This guarantees the downstream switch finishes its damp phase before a new ARM can fire.
  - If ABORT and the period-counter terminal count occur in the same cycle, ABORT wins: no next FIRE.
- ARM is ignored in every state except IDLE. An ARM held high re-arms on the cycle after the return to IDLE.
- SHOT_IDX wraps modulo 2^CNT_WIDTH in continuous mode. The shots-issued counter used for termination must not wrap: it saturates, or termination compares against `num_shots` first.

## Timing
- ARM sampled at edge N → LOAD in cycle N+1 → first START high in cycle N+2.
- Consecutive START pulses are exactly `shot_period` cycles apart (rising edge to rising edge).
- Last START at cycle M → DONE high at cycle M+shot_period, BUSY low from M+shot_period+1.
- ERR_CFG is high in cycle N+2; BUSY is high only in cycle N+1.
- Asynchronous RESET mid-burst: all outputs clear immediately, state IDLE. START must drop combinationally with RESET, because START is a register cleared by the asynchronous reset.

## Structure
- Shared package `us_tx_pkg` holds:
  - the state encoding: one-hot, five states plus DRAIN;
  - the `MIN_PERIOD_OVERHEAD = 4` constant;
  - the REG_WIDTH default, shared with the transmit switch.
- One natural sub-module: `us_period_counter`. It is a loadable down-counter with `load`, `en` and `tc` (terminal count). FIRE, WAIT and DRAIN all use it.
- The shadow registers and the `min_period` comparator stay in the top module.

## Test plan
- Single shot: init=4, tx=8, damp=6, period=40, shots=1 → exactly one START 2 cycles after ARM. DONE 40 cycles after START. SHOT_IDX=0. `_o` outputs equal 4/8/6.
- Burst: period=50, shots=5 → 5 START pulses spaced 50 cycles apart. SHOT_IDX=0..4. One DONE. Config inputs changed mid-burst do not alter the `_o` outputs.
- Config reject: init=10, tx=10, damp=10, period=33 → ERR_CFG, no START. Then period=34 → accepted.
- Continuous plus abort: shots=0, period=20. Assert ABORT 5 cycles after the third START → no fourth START. BUSY falls 15 cycles later. No DONE.
- Terminal-count collision: ABORT in the same cycle as the period terminal count → no further START, BUSY drops the next cycle, no DONE.
- Async reset mid-WAIT: RESET pulse → START, BUSY, SHOT_IDX read 0 immediately. The next ARM starts a fresh burst from shot 0.

Source files
------------

// File: rtl/us_tx_pkg.sv
// Shared transmit-path definitions: sequencer state encoding and timing constants.
package us_tx_pkg;

  // Register width shared with the transmit switch timing words.
  localparam int REG_WIDTH_DEFAULT = 8;

  // Fixed cycles of handshake overhead added to init + tx + damp.
  localparam int MIN_PERIOD_OVERHEAD = 4;

  // One-hot shot sequencer states.
  typedef enum logic [5:0] {
    ST_IDLE   = 6'b000001,
    ST_LOAD   = 6'b000010,
    ST_FIRE   = 6'b000100,
    ST_WAIT   = 6'b001000,
    ST_FINISH = 6'b010000,
    ST_DRAIN  = 6'b100000
  } seq_state_t;

endpackage

// File: rtl/us_shot_sequencer_if.sv
// Control/status bundle between the burst controller and the shot sequencer.
interface us_shot_sequencer_if import us_tx_pkg::*; #(
  parameter int REG_WIDTH    = REG_WIDTH_DEFAULT,
  parameter int PERIOD_WIDTH = 16,
  parameter int CNT_WIDTH    = 8
);
  logic                    ARM;
  logic                    ABORT;
  logic [REG_WIDTH-1:0]    init_delay;
  logic [REG_WIDTH-1:0]    tx_len;
  logic [REG_WIDTH-1:0]    damp_len;
  logic [PERIOD_WIDTH-1:0] shot_period;
  logic [CNT_WIDTH-1:0]    num_shots;
  logic                    START;
  logic [REG_WIDTH-1:0]    init_delay_o;
  logic [REG_WIDTH-1:0]    tx_len_o;
  logic [REG_WIDTH-1:0]    damp_len_o;
  logic                    BUSY;
  logic                    DONE;
  logic                    ERR_CFG;
  logic [CNT_WIDTH-1:0]    SHOT_IDX;

  modport master (
    output ARM, ABORT, init_delay, tx_len, damp_len, shot_period, num_shots,
    input  START, init_delay_o, tx_len_o, damp_len_o, BUSY, DONE, ERR_CFG, SHOT_IDX
  );

  modport slave (
    input  ARM, ABORT, init_delay, tx_len, damp_len, shot_period, num_shots,
    output START, init_delay_o, tx_len_o, damp_len_o, BUSY, DONE, ERR_CFG, SHOT_IDX
  );
endinterface

// File: rtl/us_period_counter.sv
// Loadable down-counter pacing shot spacing; tc flags the decrement that lands on zero.
module us_period_counter import us_tx_pkg::*; #(
  parameter int WIDTH = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             load,
  input  logic             en,
  input  logic [WIDTH-1:0] load_value,
  output logic             tc
);
  logic [WIDTH-1:0] count;

  // Load has priority; otherwise count down while enabled, holding at zero.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      count <= {WIDTH{1'b0}};
    end else if (load) begin
      count <= load_value;
    end else if (en && (count != {WIDTH{1'b0}})) begin
      count <= count - WIDTH'(1);
    end else begin
      count <= count;
    end
  end

  // Terminal count in the cycle whose decrement reaches zero, so the
  // next state change lands exactly one period after the load.
  assign tc = en && (count <= WIDTH'(1));
endmodule

// File: rtl/us_shot_sequencer.sv
// Shot sequencer: captures a burst configuration, validates it and issues
// START pulses at a fixed repetition interval.
module us_shot_sequencer import us_tx_pkg::*; #(
  parameter int REG_WIDTH    = REG_WIDTH_DEFAULT,
  parameter int PERIOD_WIDTH = 16,
  parameter int CNT_WIDTH    = 8
) (
  input logic CLK,
  input logic RESET,
  us_shot_sequencer_if.slave bus
);
  localparam int MIN_W = REG_WIDTH + 2;
  localparam int CMP_W = (PERIOD_WIDTH > MIN_W) ? PERIOD_WIDTH : MIN_W;

  seq_state_t              state, next_state;
  logic [REG_WIDTH-1:0]    init_q, tx_q, damp_q;
  logic [PERIOD_WIDTH-1:0] period_q;
  logic [CNT_WIDTH-1:0]    shots_q;
  logic [CNT_WIDTH-1:0]    shots_issued;
  logic [CNT_WIDTH-1:0]    shot_idx;
  logic                    start, busy, done, err_cfg;
  logic                    cnt_load, cnt_en, cnt_tc, reject;
  logic [MIN_W-1:0]        min_period;
  logic                    cfg_bad, more_shots;

  // Worst case 3*(2^REG_WIDTH-1)+4 fits in REG_WIDTH+2 bits, so no overflow.
  assign min_period = MIN_W'(init_q) + MIN_W'(tx_q) + MIN_W'(damp_q)
                    + MIN_W'(MIN_PERIOD_OVERHEAD);
  assign cfg_bad    = (period_q == {PERIOD_WIDTH{1'b0}})
                    || (CMP_W'(period_q) < CMP_W'(min_period));
  // Termination compares against the saturating count, never a wrapped index.
  assign more_shots = (shots_q == {CNT_WIDTH{1'b0}}) || (shots_issued < shots_q);

  us_period_counter #(.WIDTH(PERIOD_WIDTH)) u_period (
    .CLK        (CLK),
    .RESET      (RESET),
    .load       (cnt_load),
    .en         (cnt_en),
    .load_value (period_q - PERIOD_WIDTH'(1)),
    .tc         (cnt_tc)
  );

  // State register.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= ST_IDLE;
    else       state <= next_state;
  end

  // Next-state and counter control; ABORT outranks the terminal count.
  always_comb begin
    next_state = state;
    cnt_load   = 1'b0;
    cnt_en     = 1'b0;
    reject     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.ARM) next_state = ST_LOAD;
        else         next_state = ST_IDLE;
      end
      ST_LOAD: begin
        if (bus.ABORT) begin
          next_state = ST_IDLE;
        end else if (cfg_bad) begin
          next_state = ST_IDLE;
          reject     = 1'b1;
        end else begin
          next_state = ST_FIRE;
        end
      end
      ST_FIRE: begin
        cnt_load = 1'b1;
        if (bus.ABORT) next_state = ST_DRAIN;
        else           next_state = ST_WAIT;
      end
      ST_WAIT: begin
        cnt_en = 1'b1;
        if (bus.ABORT) begin
          if (cnt_tc) next_state = ST_IDLE;
          else        next_state = ST_DRAIN;
        end else if (cnt_tc) begin
          if (more_shots) next_state = ST_FIRE;
          else            next_state = ST_FINISH;
        end else begin
          next_state = ST_WAIT;
        end
      end
      ST_FINISH: next_state = ST_IDLE;
      ST_DRAIN: begin
        cnt_en = 1'b1;
        if (cnt_tc) next_state = ST_IDLE;
        else        next_state = ST_DRAIN;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Shadow configuration captured on ARM and held for the whole burst.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      init_q   <= {REG_WIDTH{1'b0}};
      tx_q     <= {REG_WIDTH{1'b0}};
      damp_q   <= {REG_WIDTH{1'b0}};
      period_q <= {PERIOD_WIDTH{1'b0}};
      shots_q  <= {CNT_WIDTH{1'b0}};
    end else if ((state == ST_IDLE) && bus.ARM) begin
      init_q   <= bus.init_delay;
      tx_q     <= bus.tx_len;
      damp_q   <= bus.damp_len;
      period_q <= bus.shot_period;
      shots_q  <= bus.num_shots;
    end
  end

  // Shot bookkeeping: saturating issued count and wrapping reported index.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      shots_issued <= {CNT_WIDTH{1'b0}};
      shot_idx     <= {CNT_WIDTH{1'b0}};
    end else begin
      if ((state == ST_IDLE) && bus.ARM)
        shots_issued <= {CNT_WIDTH{1'b0}};
      else if ((state == ST_FIRE) && (shots_issued != {CNT_WIDTH{1'b1}}))
        shots_issued <= shots_issued + CNT_WIDTH'(1);
      if (next_state == ST_FIRE)
        shot_idx <= (state == ST_LOAD) ? {CNT_WIDTH{1'b0}} : shot_idx + CNT_WIDTH'(1);
    end
  end

  // Registered status outputs aligned with the state being entered.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      start   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err_cfg <= 1'b0;
    end else begin
      start   <= (next_state == ST_FIRE);
      busy    <= (next_state != ST_IDLE);
      done    <= (next_state == ST_FINISH);
      err_cfg <= reject;
    end
  end

  assign bus.START        = start;
  assign bus.BUSY         = busy;
  assign bus.DONE         = done;
  assign bus.ERR_CFG      = err_cfg;
  assign bus.SHOT_IDX     = shot_idx;
  assign bus.init_delay_o = init_q;
  assign bus.tx_len_o     = tx_q;
  assign bus.damp_len_o   = damp_q;
endmodule

// File: tb/tb_us_shot_sequencer.sv
// Directed self-checking bench for us_shot_sequencer.
module tb_us_shot_sequencer;
  localparam int RW = 8;
  localparam int PW = 16;
  localparam int CW = 8;

  logic CLK = 1'b0;
  logic RESET;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  int   start_cyc[$];
  int   idx_log[$];
  int   done_cnt, done_cyc, err_cnt, err_cyc, arm_cyc;

  us_shot_sequencer_if #(.REG_WIDTH(RW), .PERIOD_WIDTH(PW), .CNT_WIDTH(CW)) bus ();

  us_shot_sequencer #(.REG_WIDTH(RW), .PERIOD_WIDTH(PW), .CNT_WIDTH(CW)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  // Cycle index: cycle k is the interval after the k-th rising edge.
  always @(posedge CLK) cyc++;

  // Event recorder sampled on the falling edge.
  always @(negedge CLK) begin
    if (bus.START === 1'b1) begin
      start_cyc.push_back(cyc);
      idx_log.push_back(int'(bus.SHOT_IDX));
    end
    if (bus.DONE === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (bus.ERR_CFG === 1'b1) begin
      err_cnt++;
      err_cyc = cyc;
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge CLK);
    #1;
  endtask

  task automatic arm(input logic [7:0] i, input logic [7:0] t, input logic [7:0] d,
                     input logic [15:0] p, input logic [7:0] n);
    bus.init_delay  = i;
    bus.tx_len      = t;
    bus.damp_len    = d;
    bus.shot_period = p;
    bus.num_shots   = n;
    start_cyc.delete();
    idx_log.delete();
    done_cnt = 0;
    err_cnt  = 0;
    done_cyc = -1;
    err_cyc  = -1;
    bus.ARM  = 1'b1;
    arm_cyc  = cyc;
    step(1);
    bus.ARM  = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output int idle_at, output bit to);
    to = 1'b1;
    idle_at = -1;
    for (int j = 0; j < budget; j++) begin
      if (bus.BUSY === 1'b0) begin
        to = 1'b0;
        idle_at = cyc;
        break;
      end
      step(1);
    end
  endtask

  task automatic wait_starts(input int n, input int budget);
    for (int j = 0; j < budget && start_cyc.size() < n; j++) step(1);
  endtask

  task automatic test_reset;
    RESET = 1'b1;
    bus.ARM = 1'b0; bus.ABORT = 1'b0;
    bus.init_delay = 8'd0; bus.tx_len = 8'd0; bus.damp_len = 8'd0;
    bus.shot_period = 16'd0; bus.num_shots = 8'd0;
    step(3);
    checks++;
    if ({bus.START, bus.BUSY, bus.DONE, bus.ERR_CFG} !== 4'b0000) begin
      failures++; $display("FAIL reset_status got=%b want=0000", {bus.START, bus.BUSY, bus.DONE, bus.ERR_CFG});
    end
    checks++;
    if ({bus.SHOT_IDX, bus.init_delay_o, bus.tx_len_o, bus.damp_len_o} !== 32'd0) begin
      failures++; $display("FAIL reset_values got=%h want=0", {bus.SHOT_IDX, bus.init_delay_o, bus.tx_len_o, bus.damp_len_o});
    end
    RESET = 1'b0;
    step(2);
    checks++;
    if (bus.BUSY !== 1'b0) begin
      failures++; $display("FAIL reset_idle_busy got=%b want=0", bus.BUSY);
    end
  endtask

  task automatic test_single_shot;
    int idle_at; bit to;
    arm(8'd4, 8'd8, 8'd6, 16'd40, 8'd1);
    wait_idle(200, idle_at, to);
    checks++;
    if (to !== 1'b0) begin failures++; $display("FAIL single_timeout got=%b want=0", to); end
    checks++;
    if (start_cyc.size() !== 1) begin failures++; $display("FAIL single_count got=%0d want=1", start_cyc.size()); end
    checks++;
    if (start_cyc[0] !== arm_cyc + 2) begin failures++; $display("FAIL single_latency got=%0d want=%0d", start_cyc[0], arm_cyc + 2); end
    checks++;
    if (idx_log[0] !== 0) begin failures++; $display("FAIL single_idx got=%0d want=0", idx_log[0]); end
    checks++;
    if (done_cnt !== 1 || done_cyc !== arm_cyc + 42) begin
      failures++; $display("FAIL single_done got=%0d@%0d want=1@%0d", done_cnt, done_cyc, arm_cyc + 42);
    end
    checks++;
    if (idle_at !== arm_cyc + 43) begin failures++; $display("FAIL single_busy_fall got=%0d want=%0d", idle_at, arm_cyc + 43); end
    checks++;
    if ({bus.init_delay_o, bus.tx_len_o, bus.damp_len_o} !== {8'd4, 8'd8, 8'd6}) begin
      failures++; $display("FAIL single_outs got=%h want=040806", {bus.init_delay_o, bus.tx_len_o, bus.damp_len_o});
    end
  endtask

  task automatic test_burst;
    int idle_at; bit to;
    arm(8'd1, 8'd2, 8'd3, 16'd50, 8'd5);
    step(60);
    bus.init_delay = 8'd200; bus.tx_len = 8'd201; bus.damp_len = 8'd202;
    bus.shot_period = 16'd7; bus.num_shots = 8'd1;
    bus.ARM = 1'b1;
    step(1);
    bus.ARM = 1'b0;
    checks++;
    if ({bus.init_delay_o, bus.tx_len_o, bus.damp_len_o} !== {8'd1, 8'd2, 8'd3}) begin
      failures++; $display("FAIL burst_shadow got=%h want=010203", {bus.init_delay_o, bus.tx_len_o, bus.damp_len_o});
    end
    wait_idle(400, idle_at, to);
    checks++;
    if (to !== 1'b0) begin failures++; $display("FAIL burst_timeout got=%b want=0", to); end
    checks++;
    if (start_cyc.size() !== 5) begin failures++; $display("FAIL burst_count got=%0d want=5", start_cyc.size()); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (start_cyc[i] !== arm_cyc + 2 + 50 * i) begin
        failures++; $display("FAIL burst_spacing[%0d] got=%0d want=%0d", i, start_cyc[i], arm_cyc + 2 + 50 * i);
      end
      checks++;
      if (idx_log[i] !== i) begin failures++; $display("FAIL burst_idx[%0d] got=%0d want=%0d", i, idx_log[i], i); end
    end
    checks++;
    if (done_cnt !== 1 || done_cyc !== arm_cyc + 252) begin
      failures++; $display("FAIL burst_done got=%0d@%0d want=1@%0d", done_cnt, done_cyc, arm_cyc + 252);
    end
  endtask

  task automatic test_cfg_reject;
    int idle_at; bit to;
    arm(8'd10, 8'd10, 8'd10, 16'd33, 8'd1);
    wait_idle(20, idle_at, to);
    step(3);
    checks++;
    if (err_cnt !== 1 || err_cyc !== arm_cyc + 2) begin
      failures++; $display("FAIL reject_err got=%0d@%0d want=1@%0d", err_cnt, err_cyc, arm_cyc + 2);
    end
    checks++;
    if (start_cyc.size() !== 0) begin failures++; $display("FAIL reject_start got=%0d want=0", start_cyc.size()); end
    checks++;
    if (idle_at !== arm_cyc + 2) begin failures++; $display("FAIL reject_busy got=%0d want=%0d", idle_at, arm_cyc + 2); end
    arm(8'd10, 8'd10, 8'd10, 16'd34, 8'd1);
    wait_idle(100, idle_at, to);
    checks++;
    if (err_cnt !== 0 || start_cyc.size() !== 1 || done_cnt !== 1) begin
      failures++; $display("FAIL accept_34 got=err%0d/start%0d/done%0d want=err0/start1/done1", err_cnt, start_cyc.size(), done_cnt);
    end
  endtask

  task automatic test_continuous_abort;
    int idle_at; bit to; int m;
    arm(8'd1, 8'd1, 8'd1, 16'd20, 8'd0);
    wait_starts(3, 200);
    m = start_cyc[2];
    step(m + 5 - cyc);
    bus.ABORT = 1'b1;
    step(1);
    bus.ABORT = 1'b0;
    wait_idle(100, idle_at, to);
    step(30);
    checks++;
    if (start_cyc.size() !== 3) begin failures++; $display("FAIL abort_starts got=%0d want=3", start_cyc.size()); end
    checks++;
    if (idle_at !== m + 20) begin failures++; $display("FAIL abort_busy_fall got=%0d want=%0d", idle_at, m + 20); end
    checks++;
    if (done_cnt !== 0) begin failures++; $display("FAIL abort_done got=%0d want=0", done_cnt); end
  endtask

  task automatic test_tc_collision;
    int m;
    arm(8'd1, 8'd1, 8'd1, 16'd20, 8'd0);
    wait_starts(1, 20);
    m = start_cyc[0];
    step(m + 19 - cyc);
    bus.ABORT = 1'b1;
    step(1);
    bus.ABORT = 1'b0;
    checks++;
    if ({bus.BUSY, bus.START} !== 2'b00) begin
      failures++; $display("FAIL collision_next got=%b want=00", {bus.BUSY, bus.START});
    end
    step(30);
    checks++;
    if (start_cyc.size() !== 1 || done_cnt !== 0) begin
      failures++; $display("FAIL collision_after got=start%0d/done%0d want=start1/done0", start_cyc.size(), done_cnt);
    end
  endtask

  task automatic test_async_reset;
    int idle_at; bit to;
    arm(8'd1, 8'd1, 8'd1, 16'd20, 8'd3);
    wait_starts(2, 100);
    checks++;
    if ({bus.START, bus.SHOT_IDX} !== {1'b1, 8'd1}) begin
      failures++; $display("FAIL areset_pre got=%b/%0d want=1/1", bus.START, bus.SHOT_IDX);
    end
    RESET = 1'b1;
    #1;
    checks++;
    if ({bus.START, bus.BUSY, bus.SHOT_IDX, bus.init_delay_o} !== 18'd0) begin
      failures++; $display("FAIL areset_clear got=%b/%b/%0d/%0d want=0/0/0/0", bus.START, bus.BUSY, bus.SHOT_IDX, bus.init_delay_o);
    end
    step(2);
    RESET = 1'b0;
    step(1);
    arm(8'd2, 8'd2, 8'd2, 16'd20, 8'd2);
    wait_idle(200, idle_at, to);
    checks++;
    if (start_cyc.size() !== 2 || start_cyc[0] !== arm_cyc + 2) begin
      failures++; $display("FAIL areset_rearm got=%0d@%0d want=2@%0d", start_cyc.size(), start_cyc[0], arm_cyc + 2);
    end
    checks++;
    if (idx_log[0] !== 0 || idx_log[1] !== 1 || done_cnt !== 1) begin
      failures++; $display("FAIL areset_idx got=%0d,%0d done%0d want=0,1 done1", idx_log[0], idx_log[1], done_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_single_shot();
    test_burst();
    test_cfg_reject();
    test_continuous_abort();
    test_tc_collision();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
